// File: rtl/ysyx_040729_clint_arbiter_if.sv
// Requester-side channel of the CLINT arbiter: a request (valid/ready) and its response (valid/ready).
// The arbiter takes the slave modport; a requester drives the master modport.
interface ysyx_040729_clint_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
);
  logic                  rq_valid;
  logic                  rq_ready;
  logic [ADDR_WIDTH-1:0] rq_addr;
  logic [DATA_WIDTH-1:0] rq_wdata;
  logic                  rq_wen;
  logic [2:0]            rq_size;
  logic                  rs_valid;
  logic                  rs_ready;
  logic [DATA_WIDTH-1:0] rs_rdata;

  modport master (
    output rq_valid, rq_addr, rq_wdata, rq_wen, rq_size, rs_ready,
    input  rq_ready, rs_valid, rs_rdata
  );

  modport slave (
    input  rq_valid, rq_addr, rq_wdata, rq_wen, rq_size, rs_ready,
    output rq_ready, rs_valid, rs_rdata
  );
endinterface

// File: rtl/ysyx_040729_clint_arbiter.sv
// Two-requester arbiter/sequencer for the single CLINT register port (req 0 = LSU, req 1 = debug/aux).
// Define CLINT_ARB_RR_EN for round-robin arbitration; otherwise rq0 wins ties (fixed priority).
module ysyx_040729_clint_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  ysyx_040729_clint_arbiter_if.slave    rq0,
  ysyx_040729_clint_arbiter_if.slave    rq1,
  output logic                          clint_sel,
  output logic                          clint_wen,
  output logic [ADDR_WIDTH-1:0]         clint_addr,
  output logic [DATA_WIDTH-1:0]         clint_wdata,
  output logic [2:0]                    clint_size,
  input  logic [DATA_WIDTH-1:0]         clint_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LOAD  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  grant;
  logic                  accept;
  logic                  resp_ready;
  logic                  rq0_ready;
  logic                  rq1_ready;
  logic                  rs0_valid;
  logic                  rs1_valid;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_wen;
  logic [2:0]            lat_size;
  logic                  lat_id;
  logic [DATA_WIDTH-1:0] resp_data;

`ifdef CLINT_ARB_RR_EN
  logic ptr;

  // ptr names the requester preferred on a tie; a lone requester is granted regardless
  always_comb begin
    grant = 1'b0;
    if (rq0.rq_valid && rq1.rq_valid) grant = ptr;
    else                              grant = rq1.rq_valid;
  end

  always_ff @(posedge clock) begin
    if (!reset)      ptr <= 1'b0;
    else if (accept) ptr <= ~grant;
  end
`else
  always_comb begin
    grant = rq1.rq_valid & ~rq0.rq_valid;
  end
`endif

  always_comb begin
    accept     = (state == IDLE) && (rq0.rq_valid || rq1.rq_valid);
    rq0_ready  = (state == IDLE) && rq0.rq_valid && !grant;
    rq1_ready  = (state == IDLE) && rq1.rq_valid && grant;
    resp_ready = lat_id ? rq1.rs_ready : rq0.rs_ready;
    rs0_valid  = (state == RESP) && !lat_id;
    rs1_valid  = (state == RESP) && lat_id;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = lat_wen ? RESP : LOAD;
      LOAD:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write responses carry zero, so the buffer is cleared on every accept and only LOAD refills it
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wen   <= 1'b0;
      lat_size  <= '0;
      lat_id    <= 1'b0;
      resp_data <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        lat_addr  <= grant ? rq1.rq_addr  : rq0.rq_addr;
        lat_wdata <= grant ? rq1.rq_wdata : rq0.rq_wdata;
        lat_wen   <= grant ? rq1.rq_wen   : rq0.rq_wen;
        lat_size  <= grant ? rq1.rq_size  : rq0.rq_size;
        lat_id    <= grant;
        resp_data <= '0;
      end
      if (state == LOAD) resp_data <= clint_rdata;
    end
  end

  assign clint_sel    = (state == ISSUE);
  assign clint_wen    = (state == ISSUE) && lat_wen;
  assign clint_addr   = lat_addr;
  assign clint_wdata  = lat_wdata;
  assign clint_size   = lat_size;

  assign rq0.rq_ready = rq0_ready;
  assign rq1.rq_ready = rq1_ready;
  assign rq0.rs_valid = rs0_valid;
  assign rq1.rs_valid = rs1_valid;
  assign rq0.rs_rdata = rs0_valid ? resp_data : '0;
  assign rq1.rs_rdata = rs1_valid ? resp_data : '0;

endmodule

// File: tb/tb_ysyx_040729_clint_arbiter.sv
// Scoreboard bench for ysyx_040729_clint_arbiter with a behavioural CLINT (mtime/mtimecmp).
// Build with +define+CLINT_ARB_RR_EN to check the round-robin grant order instead of fixed priority.
module tb_ysyx_040729_clint_arbiter;
  localparam int DW = 64;
  localparam int AW = 16;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    size;
  } acc_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          clint_sel;
  logic          clint_wen;
  logic [AW-1:0] clint_addr;
  logic [DW-1:0] clint_wdata;
  logic [2:0]    clint_size;
  logic [DW-1:0] clint_rdata = '0;
  logic [63:0]   mtime = '0;
  logic [63:0]   mtimecmp = '0;

  int n_compared = 0;
  int n_mismatched = 0;
  bit grant_check_en = 1'b0;

  logic [DW-1:0] exp_rs0_q[$];
  logic [DW-1:0] exp_rs1_q[$];
  acc_t          exp_acc_q[$];
  int            exp_grant_q[$];

  ysyx_040729_clint_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rq0_bus ();
  ysyx_040729_clint_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rq1_bus ();

  ysyx_040729_clint_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .rq0         (rq0_bus.slave),
    .rq1         (rq1_bus.slave),
    .clint_sel   (clint_sel),
    .clint_wen   (clint_wen),
    .clint_addr  (clint_addr),
    .clint_wdata (clint_wdata),
    .clint_size  (clint_size),
    .clint_rdata (clint_rdata)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] clint_read(input logic [AW-1:0] a, input logic [2:0] sz);
    logic [63:0] raw;
    raw = '0;
    case (a)
      16'hbff8: raw = mtime;
      16'hbffc: raw = {32'h0, mtime[63:32]};
      16'h4000: raw = mtimecmp;
      16'h4004: raw = {32'h0, mtimecmp[63:32]};
      default:  raw = '0;
    endcase
    case (sz[1:0])
      2'd0:    raw = sz[2] ? {56'h0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      2'd1:    raw = sz[2] ? {48'h0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'd2:    raw = sz[2] ? {32'h0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: raw = raw;
    endcase
    return raw;
  endfunction

  // Behavioural CLINT: read data is registered, so it appears the cycle after sel & ~wen
  always @(posedge clock) begin
    if (clint_sel && !clint_wen) clint_rdata <= clint_read(clint_addr, clint_size);
    if (clint_sel && clint_wen && clint_addr == 16'h4000) mtimecmp <= clint_wdata;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    acc_t          ea;
    logic [DW-1:0] er;
    int            eg;
    if (rq0_bus.rs_valid && rq0_bus.rs_ready) begin
      if (exp_rs0_q.size() == 0) check_output("rs0_unexpected", 64'(rq0_bus.rs_valid), 64'd0);
      else begin
        er = exp_rs0_q.pop_front();
        check_output("rs0_rdata", rq0_bus.rs_rdata, er);
      end
    end
    if (rq1_bus.rs_valid && rq1_bus.rs_ready) begin
      if (exp_rs1_q.size() == 0) check_output("rs1_unexpected", 64'(rq1_bus.rs_valid), 64'd0);
      else begin
        er = exp_rs1_q.pop_front();
        check_output("rs1_rdata", rq1_bus.rs_rdata, er);
      end
    end
    if (clint_sel) begin
      if (exp_acc_q.size() == 0) check_output("clint_sel_unexpected", 64'(clint_sel), 64'd0);
      else begin
        ea = exp_acc_q.pop_front();
        check_output("clint_wen",   64'(clint_wen),  64'(ea.wen));
        check_output("clint_addr",  64'(clint_addr), 64'(ea.addr));
        check_output("clint_wdata", clint_wdata,     ea.wdata);
        check_output("clint_size",  64'(clint_size), 64'(ea.size));
      end
    end
    if (grant_check_en && (rq0_bus.rq_ready || rq1_bus.rq_ready)) begin
      if (exp_grant_q.size() == 0) check_output("grant_unexpected", 64'd1, 64'd0);
      else begin
        eg = exp_grant_q.pop_front();
        check_output("grant_id", 64'(rq1_bus.rq_ready), 64'(eg));
      end
    end
  end

  task automatic set_req(input int id, input logic v, input logic wen, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [2:0] size);
    if (id == 0) begin
      rq0_bus.rq_valid = v; rq0_bus.rq_wen = wen; rq0_bus.rq_addr = addr;
      rq0_bus.rq_wdata = wdata; rq0_bus.rq_size = size;
    end else begin
      rq1_bus.rq_valid = v; rq1_bus.rq_wen = wen; rq1_bus.rq_addr = addr;
      rq1_bus.rq_wdata = wdata; rq1_bus.rq_size = size;
    end
  endtask

  // Presents one request, waits for the handshake and records what the CLINT and requester should see
  task automatic apply_stimulus(input int id, input logic wen, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [2:0] size,
                                input logic [DW-1:0] exp_rdata, input bit push_resp);
    bit ok;
    acc_t a;
    ok = 1'b0;
    set_req(id, 1'b1, wen, addr, wdata, size);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if ((id == 0) ? rq0_bus.rq_ready : rq1_bus.rq_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_output("rq_accept_timeout", 64'd0, 64'd1);
      set_req(id, 1'b0, wen, addr, wdata, size);
      return;
    end
    a.wen = wen; a.addr = addr; a.wdata = wdata; a.size = size;
    exp_acc_q.push_back(a);
    if (push_resp) begin
      if (id == 0) exp_rs0_q.push_back(wen ? '0 : exp_rdata);
      else         exp_rs1_q.push_back(wen ? '0 : exp_rdata);
    end
    @(posedge clock); #1;
    set_req(id, 1'b0, wen, addr, wdata, size);
  endtask

  // Single transaction with latency checks: sel one cycle after accept, response at +2 (write) / +3 (read)
  task automatic single_txn(input int id, input logic wen, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [2:0] size,
                            input logic [DW-1:0] exp_rdata);
    int resp_at;
    resp_at = 0;
    apply_stimulus(id, wen, addr, wdata, size, exp_rdata, 1'b1);
    @(negedge clock);
    check_output("sel_at_t1", 64'(clint_sel), 64'd1);
    for (int k = 2; k <= 8; k++) begin
      @(negedge clock);
      if ((id == 0) ? rq0_bus.rs_valid : rq1_bus.rs_valid) begin
        resp_at = k;
        break;
      end
    end
    check_output("resp_latency", 64'(resp_at), wen ? 64'd2 : 64'd3);
    @(posedge clock); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_rs0_q.size() == 0 && exp_rs1_q.size() == 0 && exp_acc_q.size() == 0) break;
      @(negedge clock);
    end
    check_output("queues_drained", 64'(exp_rs0_q.size() + exp_rs1_q.size() + exp_acc_q.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    rq0_bus.rs_ready = 1'b1;
    rq1_bus.rs_ready = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);

    // Reset state: every output low
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_output("reset_rq0_ready", 64'(rq0_bus.rq_ready), 64'd0);
    check_output("reset_rq1_ready", 64'(rq1_bus.rq_ready), 64'd0);
    check_output("reset_rs0_valid", 64'(rq0_bus.rs_valid), 64'd0);
    check_output("reset_rs1_valid", 64'(rq1_bus.rs_valid), 64'd0);
    check_output("reset_rs0_rdata", rq0_bus.rs_rdata, 64'd0);
    check_output("reset_clint_sel", 64'(clint_sel), 64'd0);
    check_output("reset_clint_wen", 64'(clint_wen), 64'd0);
    check_output("reset_clint_addr", 64'(clint_addr), 64'd0);
    check_output("reset_clint_wdata", clint_wdata, 64'd0);
    check_output("reset_clint_size", 64'(clint_size), 64'd0);
    @(posedge clock); #1 reset = 1'b1;

    // Single transactions: write, reads, 32-bit sign-extended read of the mtime high word
    single_txn(0, 1'b1, 16'h4000, 64'h100, 3'd3, 64'd0);
    mtime = 64'h55;
    single_txn(1, 1'b0, 16'hbff8, 64'd0, 3'd3, 64'h55);
    mtime = 64'h8000_0000_0000_0000;
    single_txn(1, 1'b0, 16'hbffc, 64'd0, 3'b010, 64'hFFFF_FFFF_8000_0000);
    single_txn(0, 1'b0, 16'h4000, 64'd0, 3'd3, 64'h100);
    drain();

    // Contention: both requesters keep three transactions each outstanding
    mtime = 64'h55;
    pulse_reset();
`ifdef CLINT_ARB_RR_EN
    exp_grant_q = '{0, 1, 0, 1, 0, 1};
`else
    exp_grant_q = '{0, 0, 0, 1, 1, 1};
`endif
    grant_check_en = 1'b1;
    fork
      begin
        apply_stimulus(0, 1'b1, 16'h4000, 64'h200, 3'd3, 64'd0, 1'b1);
        apply_stimulus(0, 1'b0, 16'h4000, 64'd0, 3'd3, 64'h200, 1'b1);
        apply_stimulus(0, 1'b0, 16'h4000, 64'd0, 3'd2, 64'h200, 1'b1);
      end
      begin
        apply_stimulus(1, 1'b0, 16'hbff8, 64'd0, 3'd3, 64'h55, 1'b1);
        apply_stimulus(1, 1'b0, 16'hbffc, 64'd0, 3'd6, 64'd0, 1'b1);
        apply_stimulus(1, 1'b0, 16'hbff8, 64'd0, 3'd4, 64'h55, 1'b1);
      end
    join
    drain();
    grant_check_en = 1'b0;
    check_output("grants_consumed", 64'(exp_grant_q.size()), 64'd0);

    // Response stall: rs0 held, rq1 blocked, no CLINT traffic
    rq0_bus.rs_ready = 1'b0;
    apply_stimulus(0, 1'b0, 16'h4000, 64'd0, 3'd3, 64'h200, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (rq0_bus.rs_valid) break;
    end
    set_req(1, 1'b1, 1'b0, 16'hbff8, 64'd0, 3'd3);
    repeat (10) begin
      @(negedge clock);
      check_output("stall_rs0_valid", 64'(rq0_bus.rs_valid), 64'd1);
      check_output("stall_rs0_rdata", rq0_bus.rs_rdata, 64'h200);
      check_output("stall_rq1_ready", 64'(rq1_bus.rq_ready), 64'd0);
      check_output("stall_clint_sel", 64'(clint_sel), 64'd0);
    end
    @(posedge clock); #1 rq0_bus.rs_ready = 1'b1;
    apply_stimulus(1, 1'b0, 16'hbff8, 64'd0, 3'd3, 64'h55, 1'b1);
    drain();

    // Reset while in LOAD drops the read without a response
    apply_stimulus(0, 1'b0, 16'h4000, 64'd0, 3'd3, 64'h200, 1'b0);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check_output("drop_rs0_valid", 64'(rq0_bus.rs_valid), 64'd0);
      check_output("drop_clint_sel", 64'(clint_sel), 64'd0);
    end
    @(posedge clock); #1;
    single_txn(0, 1'b0, 16'h4000, 64'd0, 3'd3, 64'h200);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
